// File: rtl/order_gate.sv
`default_nettype none
// ============================================================================
//  Module      : order_gate
//  Description : Order admission gate between a strategy and a risk check.
//                Accepts one request at a time, fires a one-cycle risk check,
//                then rejects the order or sends it downstream. It tracks the
//                order through one or more fills and owns the signed net
//                position.
//  Optional    : ORDER_TIMEOUT_EN - cancels the unfilled remainder after
//                TIMEOUT_CYCLES fill-less cycles in WAIT_FILL (o_timeout pulse).
//  Ports       : i_clk/i_rst_n        clock, async active-low reset
//                i_req_*/o_req_ready  strategy request handshake and payload
//                o_risk_*             latched request and start pulse to risk
//                i_risk_valid/hold    risk decision
//                o_ord_*/i_ord_ready  downstream order handshake and payload
//                i_fill_*             fill strobe and quantity
//                o_position           signed net position
//                o_rejected/o_timeout one-cycle status pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module order_gate #(
  parameter int DATA_WIDTH     = 32,
  parameter int QTY_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_signal,
  input  logic [QTY_WIDTH-1:0]  i_req_quantity,
  input  logic [DATA_WIDTH-1:0] i_risk_limit,
  output logic                  o_risk_start,
  output logic                  o_risk_signal,
  output logic [QTY_WIDTH-1:0]  o_risk_quantity,
  output logic [DATA_WIDTH-1:0] o_risk_limit,
  output logic [DATA_WIDTH-1:0] o_position,
  input  logic                  i_risk_hold,
  input  logic                  i_risk_valid,
  output logic                  o_ord_valid,
  input  logic                  i_ord_ready,
  output logic                  o_ord_signal,
  output logic [QTY_WIDTH-1:0]  o_ord_quantity,
  input  logic                  i_fill_valid,
  input  logic [QTY_WIDTH-1:0]  i_fill_quantity,
  output logic                  o_rejected,
  output logic                  o_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RISK_REQ  = 3'd1,
    ST_RISK_WAIT = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_FILL = 3'd4
  } state_e;

  state_e                state_q,     state_d;
  logic                  side_q,      side_d;
  logic [QTY_WIDTH-1:0]  qty_q,       qty_d;
  logic [DATA_WIDTH-1:0] limit_q,     limit_d;
  logic [QTY_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] position_q,  position_d;
  logic                  rejected_q,  rejected_d;
  logic                  timeout_q,   timeout_d;

  logic [QTY_WIDTH-1:0]  applied;
  logic [DATA_WIDTH-1:0] applied_ext;
  logic                  expire;

`ifdef ORDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts consecutive fill-less cycles; any fill or any other state clears it,
  // so entry into WAIT_FILL always starts from zero.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_WAIT_FILL && !i_fill_valid) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry on the TIMEOUT_CYCLES-th silent cycle; a fill in that cycle wins.
  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !i_fill_valid;
`else
  localparam logic unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign expire = 1'b0;
`endif

  // Fill is clipped to what is still outstanding.
  assign applied     = (i_fill_quantity < remaining_q) ? i_fill_quantity : remaining_q;
  assign applied_ext = {{(DATA_WIDTH-QTY_WIDTH){1'b0}}, applied};

  always_comb begin
    state_d     = state_q;
    side_d      = side_q;
    qty_d       = qty_q;
    limit_d     = limit_q;
    remaining_d = remaining_q;
    position_d  = position_q;
    rejected_d  = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          side_d  = i_req_signal;
          qty_d   = i_req_quantity;
          limit_d = i_risk_limit;
          if (i_req_quantity == '0) begin
            rejected_d = 1'b1;
          end else begin
            state_d = ST_RISK_REQ;
          end
        end
      end
      ST_RISK_REQ: begin
        state_d = ST_RISK_WAIT;
      end
      ST_RISK_WAIT: begin
        if (i_risk_valid) begin
          if (i_risk_hold) begin
            rejected_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (i_ord_ready) begin
          remaining_d = qty_q;
          state_d     = ST_WAIT_FILL;
        end
      end
      ST_WAIT_FILL: begin
        if (i_fill_valid) begin
          position_d  = side_q ? (position_q - applied_ext) : (position_q + applied_ext);
          remaining_d = remaining_q - applied;
          if (remaining_d == '0) begin
            state_d = ST_IDLE;
          end
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      side_q      <= 1'b0;
      qty_q       <= '0;
      limit_q     <= '0;
      remaining_q <= '0;
      position_q  <= '0;
      rejected_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      side_q      <= side_d;
      qty_q       <= qty_d;
      limit_q     <= limit_d;
      remaining_q <= remaining_d;
      position_q  <= position_d;
      rejected_q  <= rejected_d;
      timeout_q   <= timeout_d;
    end
  end

  // Risk and order payloads share the request latch: both are fixed from
  // accept until the return to IDLE.
  assign o_req_ready     = (state_q == ST_IDLE);
  assign o_risk_start    = (state_q == ST_RISK_REQ);
  assign o_risk_signal   = side_q;
  assign o_risk_quantity = qty_q;
  assign o_risk_limit    = limit_q;
  assign o_ord_valid     = (state_q == ST_SEND);
  assign o_ord_signal    = side_q;
  assign o_ord_quantity  = qty_q;
  assign o_position      = position_q;
  assign o_rejected      = rejected_q;
  assign o_timeout       = timeout_q;

endmodule
`default_nettype wire
